ps2_key_decoder: RTL

- Receives PS/2 keyboard frames and decodes make/break scancodes.
- Drives the 4-bit `key` bus that the player control blocks compare against the `key_*` constants in vga_pkg.
- Sits between the board PS/2 pins and the game logic, in the system clock domain.
- Holds the code of the currently pressed recognised key, or key_NONE when no recognised key is held.

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/ps2_rx.sv | 146 ++++++++++++++
 rtl/ps2_key_decoder.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - key codes, scancodes, FSM state types and scancode map
//
// Shared by ps2_rx and ps2_key_decoder.
//   key_*        4-bit key codes driven on ps2_key_decoder.key
//   SC_*         PS/2 set-2 scancodes (SC_UP..SC_RIGHT follow an SC_EXT prefix)
//   rx_state_t   frame receiver states
//   kb_state_t   make/break/extended prefix states
//   map_scancode translates a scancode (plus extended flag) to a key code
package vga_pkg;

  localparam logic [3:0] key_NONE  = 4'h0;
  localparam logic [3:0] key_W     = 4'h1;
  localparam logic [3:0] key_S     = 4'h2;
  localparam logic [3:0] key_A     = 4'h3;
  localparam logic [3:0] key_D     = 4'h4;
  localparam logic [3:0] key_SPACE = 4'h5;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_CHECK} rx_state_t;
  typedef enum logic [1:0] {BASE, BRK, EXT, EXT_BRK} kb_state_t;

  function automatic logic [3:0] map_scancode(input logic ext, input logic [7:0] code);
    logic [3:0] k;
    k = key_NONE;
    if (!ext) begin
      case (code)
        SC_W:     k = key_W;
        SC_S:     k = key_S;
        SC_A:     k = key_A;
        SC_D:     k = key_D;
        SC_SPACE: k = key_SPACE;
        default:  k = key_NONE;
      endcase
    end else begin
      case (code)
        SC_UP:    k = key_W;
        SC_DOWN:  k = key_S;
        SC_LEFT:  k = key_A;
        SC_RIGHT: k = key_D;
        default:  k = key_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronisers, clock filter, frame FSM, timeout
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   ps2_clk         raw PS/2 clock pin (asynchronous)
//   ps2_data        raw PS/2 data pin (asynchronous)
//   rx_byte[7:0]    last received data byte, valid while byte_valid is high
//   byte_valid      one-cycle pulse for a frame accepted by the checks
//   frame_err       one-cycle pulse for a discarded frame (stop/parity/timeout)
// Macro PS2_PARITY_CHECK_EN: when defined, frames with wrong odd parity are
// discarded; otherwise the parity bit is ignored.
module ps2_rx
  import vga_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          strobe;
  logic [3:0]    bcnt;
  logic [7:0]    shreg;
  logic          stop_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          frame_ok;
  rx_state_t     state, state_next;

  // Synchronisers idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive samples that
  // disagree with it; a 1->0 flip is registered as the sample strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt   <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt   <= clk_s2;
        fcnt   <= '0;
        strobe <= filt;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign timeout = (state == RX_BITS) && (tcnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  assign frame_ok = stop_bit && (^{shreg, parity_bit});
`else
  assign frame_ok = stop_bit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (strobe && !dat_s2) state_next = RX_BITS;
      RX_BITS: begin
        // Timeout wins over a strobe arriving in the same cycle.
        if (timeout)                         state_next = RX_IDLE;
        else if (strobe && bcnt == 4'd9)     state_next = RX_CHECK;
      end
      RX_CHECK: state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == RX_CHECK) begin
      byte_valid = frame_ok;
      frame_err  = !frame_ok;
    end
    if (timeout) frame_err = 1'b1;
  end

  // Frame datapath: bit counter, shift register, stop/parity capture, timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt     <= '0;
      shreg    <= '0;
      stop_bit <= 1'b0;
      tcnt     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state == RX_BITS && !timeout) begin
        tcnt <= strobe ? '0 : tcnt + 1'b1;
        if (strobe) begin
          if (bcnt < 4'd8) shreg <= {dat_s2, shreg[7:1]};
`ifdef PS2_PARITY_CHECK_EN
          if (bcnt == 4'd8) parity_bit <= dat_s2;
`endif
          if (bcnt == 4'd9) stop_bit <= dat_s2;
          bcnt <= bcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
        if (state == RX_IDLE) bcnt <= '0;
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard make/break decoder driving a 4-bit key code
//
// Ports:
//   clk, rst     system clock, asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pin
//   ps2_data     raw PS/2 data pin
//   key[3:0]     currently held recognised key (vga_pkg key_*), key_NONE if none
//   key_valid    one-cycle pulse whenever key changes
//   frame_err    one-cycle pulse on every discarded frame
// Macro PS2_PARITY_CHECK_EN: enables odd-parity checking in ps2_rx.
module ps2_key_decoder
  import vga_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  kb_state_t  kb_state, kb_state_next;
  logic [3:0] key_next;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) kb_state <= BASE;
    else      kb_state <= kb_state_next;
  end

  always_comb begin
    kb_state_next = kb_state;
    if (byte_valid) begin
      case (kb_state)
        BASE: begin
          if (rx_byte == SC_EXT)      kb_state_next = EXT;
          else if (rx_byte == SC_BRK) kb_state_next = BRK;
        end
        EXT:     kb_state_next = (rx_byte == SC_BRK) ? EXT_BRK : BASE;
        BRK:     kb_state_next = BASE;
        EXT_BRK: kb_state_next = BASE;
        default: kb_state_next = BASE;
      endcase
    end
  end

  // A make only replaces key with a different recognised code; a break only
  // clears key when it releases the key currently held.
  always_comb begin
    logic [3:0] mapped;
    logic       is_make, is_break;
    mapped   = map_scancode((kb_state == EXT) || (kb_state == EXT_BRK), rx_byte);
    is_make  = 1'b0;
    is_break = 1'b0;
    key_next = key;
    if (byte_valid) begin
      case (kb_state)
        BASE:    is_make  = (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
        EXT:     is_make  = (rx_byte != SC_BRK);
        BRK:     is_break = 1'b1;
        EXT_BRK: is_break = 1'b1;
        default: ;
      endcase
    end
    if (is_make && mapped != key_NONE)
      key_next = mapped;
    if (is_break && mapped != key_NONE && mapped == key)
      key_next = key_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key       <= key_NONE;
      key_valid <= 1'b0;
    end else begin
      key       <= key_next;
      key_valid <= (key_next != key);
    end
  end

endmodule
